sgf_mult_seq: RTL and testbench

//  Iterative unsigned significand multiplier for the FPU multiply path.

---
 rtl/sgf_mult_seq.sv | 141 ++++++++++++++
 tb/tb_sgf_mult_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sgf_mult_seq.sv
// rtl/sgf_mult_seq.sv - iterative unsigned shift-add significand multiplier
// Optional macro MULT_RADIX4_EN selects the two-bits-per-cycle datapath.
module sgf_mult_seq #(
  parameter int SW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [2*SW-1:0] P_o,
  output logic            Norm_bit_o
);

`ifdef MULT_RADIX4_EN
  localparam int ITER = (SW + 1) / 2;
  localparam int STEP = 2;
  localparam int AW   = SW + 2;
  localparam int MW   = 2 * ITER;
`else
  localparam int ITER = SW;
  localparam int STEP = 1;
  localparam int AW   = SW + 1;
  localparam int MW   = SW;
`endif
  localparam int CW = $clog2(SW + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_next;
  logic [SW-1:0]   mcand;
  logic [AW-1:0]   acc;
  logic [MW-1:0]   mq;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   mcand_ext;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   sum;
  logic [AW+MW-1:0] shifted;
  logic [2*SW-1:0] p_final;
  logic            accept;
  logic            last_cyc;

  assign mcand_ext = AW'(mcand);
  assign accept    = start_i && ready_o;
  assign last_cyc  = (cnt == CW'(ITER));

`ifdef MULT_RADIX4_EN
  logic [AW-1:0] mcand3;

  always_comb begin
    addend = '0;
    case (mq[1:0])
      2'b01:   addend = mcand_ext;
      2'b10:   addend = mcand_ext << 1;
      2'b11:   addend = mcand3;
      default: addend = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      mcand3 <= '0;
    else if (accept)
      mcand3 <= AW'(Data_A_i) + (AW'(Data_A_i) << 1);
  end
`else
  always_comb begin
    addend = '0;
    if (mq[0])
      addend = mcand_ext;
  end
`endif

  assign sum     = acc + addend;
  assign shifted = {sum, mq} >> STEP;
  // For odd SW in radix-4, B was zero-extended on top, so the exact product
  // still sits in the low 2*SW bits of {acc,mq}.
  assign p_final = {acc[2*SW-MW-1:0], mq};

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i)
          state_next = RUN;
      end
      RUN: begin
        if (last_cyc)
          state_next = DONE;
      end
      DONE: begin
        ready_o    = 1'b1;
        done_o     = 1'b1;
        state_next = start_i ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand      <= '0;
      acc        <= '0;
      mq         <= '0;
      cnt        <= '0;
      P_o        <= '0;
      Norm_bit_o <= 1'b0;
    end else if (accept) begin
      mcand <= Data_A_i;
      mq    <= MW'(Data_B_i);
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      if (last_cyc) begin
        P_o        <= p_final;
        Norm_bit_o <= p_final[2*SW-1];
      end else begin
        acc <= shifted[AW+MW-1:MW];
        mq  <= shifted[MW-1:0];
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sgf_mult_seq.sv
// tb/tb_sgf_mult_seq.sv - self-checking bench for sgf_mult_seq (SW=24)
// Honours MULT_RADIX4_EN for the expected latency.
module tb_sgf_mult_seq;

`ifdef MULT_RADIX4_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 25;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [23:0] Data_A_i;
  logic [23:0] Data_B_i;
  logic        ready_o;
  logic        done_o;
  logic [47:0] P_o;
  logic        Norm_bit_o;

  sgf_mult_seq #(.SW(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .Data_A_i   (Data_A_i),
    .Data_B_i   (Data_B_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .P_o        (P_o),
    .Norm_bit_o (Norm_bit_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
    logic        norm;
  } vec_t;

  typedef struct {
    logic [47:0] p;
    logic        norm;
    int          due;
  } pend_t;

  vec_t        vecs[7];
  pend_t       pend[$];
  int          errors = 0;
  int          checks = 0;
  int          edge_n = 0;
  int          n_done = 0;
  logic        exp_ready = 1'b1;
  logic [47:0] last_p = '0;
  logic        last_norm = 1'b0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] x, y;
    x = {24'b0, a};
    y = {24'b0, b};
    return x * y;
  endfunction

  // One clock: drive inputs, predict acceptance, then compare every output.
  task automatic step(input logic s, input logic [23:0] a, input logic [23:0] b,
                      input logic [47:0] p, input logic norm);
    logic exp_done;
    start_i  = s;
    Data_A_i = a;
    Data_B_i = b;
    if (s && exp_ready)
      pend.push_back('{p: p, norm: norm, due: edge_n + 1 + LAT});
    @(posedge clk);
    #1;
    edge_n++;
    exp_done  = (pend.size() > 0) && (pend[0].due == edge_n);
    exp_ready = (pend.size() == 0) || exp_done;
    chk("done_o", {47'b0, done_o}, {47'b0, exp_done});
    chk("ready_o", {47'b0, ready_o}, {47'b0, exp_ready});
    if (exp_done) begin
      last_p    = pend[0].p;
      last_norm = pend[0].norm;
      void'(pend.pop_front());
    end
    if (done_o)
      n_done++;
    chk("P_o", P_o, last_p);
    chk("Norm_bit_o", {47'b0, Norm_bit_o}, {47'b0, last_norm});
  endtask

  task automatic drain();
    int n = 0;
    while (pend.size() > 0 && n < LAT + 5) begin
      step(1'b0, 24'h0, 24'h0, 48'h0, 1'b0);
      n++;
    end
    if (pend.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL timeout: %0d results outstanding", pend.size());
      pend.delete();
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    edge_n++;
    pend.delete();
    last_p    = '0;
    last_norm = 1'b0;
    exp_ready = 1'b1;
    chk("rst ready_o", {47'b0, ready_o}, 48'h1);
    chk("rst done_o", {47'b0, done_o}, 48'h0);
    chk("rst P_o", P_o, 48'h0);
    chk("rst Norm_bit_o", {47'b0, Norm_bit_o}, 48'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [23:0] ra, rb;
    logic [47:0] rp;
    int d0;

    vecs[0] = '{24'h800000, 24'h800000, 48'h400000000000, 1'b0};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1};
    vecs[2] = '{24'hC00000, 24'hC00000, 48'h900000000000, 1'b1};
    vecs[3] = '{24'h000000, 24'hABCDEF, 48'h000000000000, 1'b0};
    vecs[4] = '{24'h800000, 24'hFFFFFF, 48'h7FFFFF800000, 1'b0};
    vecs[5] = '{24'h000001, 24'h000001, 48'h000000000001, 1'b0};
    vecs[6] = '{24'hFFFFFF, 24'h000002, 48'h000001FFFFFE, 1'b0};

    rst      = 1'b1;
    start_i  = 1'b0;
    Data_A_i = '0;
    Data_B_i = '0;
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].norm);
      drain();
      step(1'b0, 24'h0, 24'h0, 48'h0, 1'b0);
    end

    // Back-to-back with operands changing every cycle.
    d0 = n_done;
    for (int i = 0; i < 3 * LAT; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      rp = ref_mul(ra, rb);
      step(1'b1, ra, rb, rp, rp[47]);
    end
    drain();
    chk("b2b done count", 48'(n_done - d0), 48'd3);

    // Reset during iteration 10 discards the partial product.
    step(1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b0, 24'h0, 24'h0, 48'h0, 1'b0);
    do_reset();
    step(1'b1, vecs[2].a, vecs[2].b, vecs[2].p, vecs[2].norm);
    drain();

    for (int i = 0; i < 20000; i++) begin
      ra = 24'($urandom) | 24'h800000;
      rb = 24'($urandom) | 24'h800000;
      rp = ref_mul(ra, rb);
      step($urandom_range(0, 3) != 0, ra, rb, rp, rp[47]);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
